id_issue_ctrl: RTL and testbench
================================

ID_ISSUE_CTRL -- requirements
Module: id_issue_ctrl

Interface
REQ-001 SHALL have ports: clk in 1 system clock; rst_n in 1 asynchronous active-low reset.
REQ-002 SHALL have decode-side inputs, each 1 bit unless stated, from the decode stage:
- id_valid: decoded instruction present.
- rs1_index, rs2_index, rd_index: 5 bits each.
- rs1_en, rs2_en, rd_en.
- inst_load, inst_csr.
REQ-003 SHALL have handshake ports:
- ex_ready in 1: execute stage accepts.
- issue_valid out 1: instruction handed to execute.
- id_ready out 1: decode slot may advance.
- flush in 1: branch/jump redirect; kills the decode-slot instruction.
REQ-004 SHALL have writeback inputs: wb_valid in 1, wb_rd_index in 5: retirement of one register write.
REQ-005 SHALL have status outputs:
- stall out 1: hazard hold.
- busy_vec out 32: scoreboard.
- inflight_cnt out 3: outstanding writers.

Function
REQ-006 SHALL keep a 32-bit scoreboard busy_vec; bit 0 is never set.
REQ-007 SHALL flag a hazard when:
- rs1_en and busy_vec[rs1_index] are set, or
- rs2_en and busy_vec[rs2_index] are set, or
- rd_en and busy_vec[rd_index] are set (WAW).
REQ-008 SHALL assert stall combinationally when any of the following holds, and id_valid is high:
- hazard;
- inflight_cnt==4;
- FSM state is DRAIN.
REQ-009 SHALL drive issue_valid = id_valid & ~stall & ~flush & (state==RUN).
REQ-010 SHALL drive id_ready = (issue_valid & ex_ready) | ~id_valid | flush.
REQ-011 SHALL, on a completed issue (issue_valid & ex_ready) with rd_en & rd_index!=0:
- set busy_vec[rd_index] at the next clock edge;
- increment inflight_cnt.
REQ-012 SHALL, on wb_valid with wb_rd_index!=0:
- clear busy_vec[wb_rd_index];
- decrement inflight_cnt.
wb_valid with a non-busy index is ignored; the count does not go negative.
REQ-013 SHALL, when a set and a clear target the same index in one cycle, leave the bit set and leave the count unchanged.
REQ-014 SHALL have a 2-state FSM:
- RUN -> DRAIN when id_valid & inst_csr & inflight_cnt!=0 & ~flush.
- DRAIN -> RUN when inflight_cnt==0 (the next-state count, i.e. after the same-cycle wb).
- flush in DRAIN -> RUN.
REQ-015 SHALL issue a CSR instruction only in RUN with inflight_cnt==0 (serialization).
REQ-016 SHALL add zero latency: issue is combinational in the cycle the hold conditions are clear.
REQ-017 SHALL leave the scoreboard and inflight_cnt untouched on flush; only the decode slot is killed.

Reset
REQ-018 SHALL, with rst_n low (asynchronous), reset to: busy_vec=0, inflight_cnt=0, state=RUN.
REQ-019 SHALL, during reset, drive stall=0 and issue_valid=0, and drive id_ready=1.
REQ-020 SHALL discard any in-flight entry when rst_n is asserted mid-operation; there is no replay.

Configuration
REQ-021 SHALL, with WB_BYPASS_EN defined, exclude from the hazard test of REQ-007 a source register whose busy bit is being cleared by wb_valid in the same cycle; this lets the instruction issue that cycle.
REQ-022 SHALL, without WB_BYPASS_EN, use the registered busy_vec only, so the instruction issues one cycle after the wb.

Structure
REQ-023 SHALL place the FSM state encoding (RUN=0, DRAIN=1) in the shared defines.v, along with:
- INFLIGHT_MAX=4;
- INFLIGHT_CNT_BUS.
REQ-024 SHALL split the scoreboard set/clear/lookup into one sub-module, id_scoreboard; the FSM, the counter and the handshake stay in id_issue_ctrl.

Verification
REQ-025 The bench SHALL cover RAW: issue a load with rd=5, then the next instruction has rs1=5:
- stall=1 until wb_valid with wb_rd_index=5;
- with WB_BYPASS_EN, issue occurs in the wb cycle;
- without WB_BYPASS_EN, issue occurs one cycle later.
REQ-026 The bench SHALL cover the full condition: issue 4 writers to rd=1..4 with no wb:
- inflight_cnt=4;
- a 5th instruction with no hazard stalls;
- one wb releases it the next cycle.
REQ-027 The bench SHALL cover CSR serialization: with 2 writers in flight, present a CSR instruction:
- state=DRAIN;
- issue_valid=0 until both wb have occurred;
- then issue_valid=1.
REQ-028 The bench SHALL cover the same-index collision: issue rd=7 and wb rd=7 in the same cycle:
- busy_vec[7]=1;
- inflight_cnt unchanged.
REQ-029 The bench SHALL cover x0 and flush:
- rd=0 writes never set a bit or increment the count;
- flush with a stalled instruction gives id_ready=1, issue_valid=0 and an unchanged scoreboard.
REQ-030 The bench SHALL cover reset mid-DRAIN: assert rst_n=0 with 3 writers in flight, then check busy_vec=0, inflight_cnt=0 and state=RUN.

Source files
------------

// File: rtl/id_issue_ctrl_pkg.sv
// Shared constants and types for the decode-stage issue controller (state encoding, inflight limit).
package id_issue_ctrl_pkg;

  localparam int         INFLIGHT_MAX     = 4;
  localparam int         INFLIGHT_CNT_BUS = 3;

  localparam logic [0:0] ST_RUN           = 1'b0;
  localparam logic [0:0] ST_DRAIN         = 1'b1;

  typedef logic [4:0]                  reg_idx_t;
  typedef logic [INFLIGHT_CNT_BUS-1:0] cnt_t;

  // x0 is hardwired zero, so its mask is always empty.
  function automatic logic [31:0] idx_mask(input reg_idx_t idx);
    return (idx == 5'd0) ? 32'd0 : (32'd1 << idx);
  endfunction

endpackage

// File: rtl/id_issue_ctrl_if.sv
// Decode/execute/writeback handshake bundle between the decode stage and the issue controller.
interface id_issue_ctrl_if;
  import id_issue_ctrl_pkg::*;

  logic        id_valid;
  reg_idx_t    rs1_index;
  reg_idx_t    rs2_index;
  reg_idx_t    rd_index;
  logic        rs1_en;
  logic        rs2_en;
  logic        rd_en;
  logic        inst_load;
  logic        inst_csr;
  logic        ex_ready;
  logic        flush;
  logic        wb_valid;
  reg_idx_t    wb_rd_index;

  logic        issue_valid;
  logic        id_ready;
  logic        stall;
  logic [31:0] busy_vec;
  cnt_t        inflight_cnt;

  modport master (
    output id_valid, rs1_index, rs2_index, rd_index, rs1_en, rs2_en, rd_en,
           inst_load, inst_csr, ex_ready, flush, wb_valid, wb_rd_index,
    input  issue_valid, id_ready, stall, busy_vec, inflight_cnt
  );

  modport slave (
    input  id_valid, rs1_index, rs2_index, rd_index, rs1_en, rs2_en, rd_en,
           inst_load, inst_csr, ex_ready, flush, wb_valid, wb_rd_index,
    output issue_valid, id_ready, stall, busy_vec, inflight_cnt
  );

endinterface

// File: rtl/id_scoreboard.sv
// Register busy scoreboard: set on issue, clear on writeback, RAW/WAW lookup.
// WB_BYPASS_EN: a source being cleared by this cycle's writeback is not treated as busy.
module id_scoreboard
  import id_issue_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_set_vld,
  input  reg_idx_t    i_set_idx,
  input  logic        i_clr_vld,
  input  reg_idx_t    i_clr_idx,
  input  logic        i_rs1_en,
  input  reg_idx_t    i_rs1_idx,
  input  logic        i_rs2_en,
  input  reg_idx_t    i_rs2_idx,
  input  logic        i_rd_en,
  input  reg_idx_t    i_rd_idx,
  output logic [31:0] o_busy_vec,
  output logic        o_hazard,
  output logic        o_clr_hit
);

  logic [31:0] r_busy;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;
  logic [31:0] w_src_busy;

  assign w_set_mask = i_set_vld ? idx_mask(i_set_idx) : 32'd0;
  assign w_clr_mask = i_clr_vld ? idx_mask(i_clr_idx) : 32'd0;

  // Set wins over clear on the same index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_busy <= 32'd0;
    else          r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
  end

`ifdef WB_BYPASS_EN
  assign w_src_busy = r_busy & ~w_clr_mask;
`else
  assign w_src_busy = r_busy;
`endif

  assign o_hazard   = (i_rs1_en & w_src_busy[i_rs1_idx]) |
                      (i_rs2_en & w_src_busy[i_rs2_idx]) |
                      (i_rd_en  & r_busy[i_rd_idx]);
  assign o_clr_hit  = |(r_busy & w_clr_mask);
  assign o_busy_vec = r_busy;

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: hazard stall, zero-latency issue, inflight counting, CSR drain FSM.
// Scoreboard lives in id_scoreboard; WB_BYPASS_EN selects writeback bypass of source hazards.
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  id_issue_ctrl_if.slave io
);

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  cnt_t        r_cnt;
  cnt_t        w_cnt_nxt;
  logic [31:0] w_busy;
  logic        w_hazard;
  logic        w_clr_hit;
  logic        w_full;
  logic        w_csr_hold;
  logic        w_stall;
  logic        w_issue;
  logic        w_fire;
  logic        w_set;
  logic        w_collide;
  logic        w_inc;
  logic        w_dec;
  logic        w_unused;

  id_scoreboard u_sb (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_set_vld  (w_set),
    .i_set_idx  (io.rd_index),
    .i_clr_vld  (io.wb_valid),
    .i_clr_idx  (io.wb_rd_index),
    .i_rs1_en   (io.rs1_en),
    .i_rs1_idx  (io.rs1_index),
    .i_rs2_en   (io.rs2_en),
    .i_rs2_idx  (io.rs2_index),
    .i_rd_en    (io.rd_en),
    .i_rd_idx   (io.rd_index),
    .o_busy_vec (w_busy),
    .o_hazard   (w_hazard),
    .o_clr_hit  (w_clr_hit)
  );

  assign w_full     = (r_cnt == cnt_t'(INFLIGHT_MAX));
  // CSRs only issue once every outstanding writer has retired.
  assign w_csr_hold = io.inst_csr & (r_cnt != '0);
  assign w_stall    = rst_n & io.id_valid &
                      (w_hazard | w_full | (r_state == ST_DRAIN) | w_csr_hold);
  assign w_issue    = rst_n & io.id_valid & ~w_stall & ~io.flush & (r_state == ST_RUN);
  assign w_fire     = w_issue & io.ex_ready;

  assign w_set      = w_fire & io.rd_en & (io.rd_index != '0);
  assign w_collide  = w_set & io.wb_valid & (io.wb_rd_index == io.rd_index);
  assign w_inc      = w_set & ~w_collide;
  assign w_dec      = w_clr_hit & ~w_collide & (r_cnt != '0);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_inc & ~w_dec)      w_cnt_nxt = r_cnt + cnt_t'(1);
    else if (w_dec & ~w_inc) w_cnt_nxt = r_cnt - cnt_t'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_RUN) begin
      if (io.id_valid & io.inst_csr & (r_cnt != '0) & ~io.flush) w_state_nxt = ST_DRAIN;
    end else if (io.flush || (w_cnt_nxt == '0)) begin
      w_state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_unused        = io.inst_load;

  assign io.stall        = w_stall;
  assign io.issue_valid  = w_issue;
  assign io.id_ready     = w_fire | ~io.id_valid | io.flush | ~rst_n;
  assign io.busy_vec     = w_busy;
  assign io.inflight_cnt = r_cnt;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed cycle-by-cycle vectors for id_issue_ctrl; expectations follow WB_BYPASS_EN when defined.
module tb_id_issue_ctrl;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  id_issue_ctrl_if bus ();

  id_issue_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        idv;
    logic [4:0]  rs1;
    logic        e1;
    logic [4:0]  rs2;
    logic        e2;
    logic [4:0]  rd;
    logic        ed;
    logic        csr;
    logic        exr;
    logic        fl;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        e_stall;
    logic        e_iss;
    logic        e_rdy;
    logic [31:0] e_busy;
    logic [2:0]  e_cnt;
    logic        e_st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic idv, logic [4:0] rs1, logic e1, logic [4:0] rs2, logic e2,
                              logic [4:0] rd, logic ed, logic csr, logic exr, logic fl,
                              logic wbv, logic [4:0] wbrd, logic st, logic iss, logic rdy,
                              logic [31:0] busy, logic [2:0] cnt, logic state);
    vec_t v;
    v.idv = idv; v.rs1 = rs1; v.e1 = e1; v.rs2 = rs2; v.e2 = e2; v.rd = rd; v.ed = ed;
    v.csr = csr; v.exr = exr; v.fl = fl; v.wbv = wbv; v.wbrd = wbrd;
    v.e_stall = st; v.e_iss = iss; v.e_rdy = rdy; v.e_busy = busy; v.e_cnt = cnt; v.e_st = state;
    return v;
  endfunction

  function automatic vec_t idle(logic wbv, logic [4:0] wbrd, logic [31:0] busy,
                                logic [2:0] cnt, logic state);
    return mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, wbv, wbrd,
              1'b0, 1'b0, 1'b1, busy, cnt, state);
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid    = v.idv;
    bus.rs1_index   = v.rs1;
    bus.rs1_en      = v.e1;
    bus.rs2_index   = v.rs2;
    bus.rs2_en      = v.e2;
    bus.rd_index    = v.rd;
    bus.rd_en       = v.ed;
    bus.inst_load   = v.ed;
    bus.inst_csr    = v.csr;
    bus.ex_ready    = v.exr;
    bus.flush       = v.fl;
    bus.wb_valid    = v.wbv;
    bus.wb_rd_index = v.wbrd;
  endtask

  task automatic check_all(input int row, input logic st, input logic iss, input logic rdy,
                           input logic [31:0] busy, input logic [2:0] cnt, input logic state);
    chk("stall",        row, 32'(bus.stall),        32'(st));
    chk("issue_valid",  row, 32'(bus.issue_valid),  32'(iss));
    chk("id_ready",     row, 32'(bus.id_ready),     32'(rdy));
    chk("busy_vec",     row, bus.busy_vec,          busy);
    chk("inflight_cnt", row, 32'(bus.inflight_cnt), 32'(cnt));
    chk("state",        row, 32'(dut.r_state),      32'(state));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;

    // RAW on a load result
    tbl.push_back(idle(0, 0, 32'h0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0,  0, 1, 1, 32'h0,  0, 0));
    tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 1, 0, 0, 0,  1, 0, 0, 32'h20, 1, 0));
`ifdef WB_BYPASS_EN
    tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 1, 0, 1, 5,  0, 1, 1, 32'h20, 1, 0));
`else
    tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 1, 0, 1, 5,  1, 0, 0, 32'h20, 1, 0));
    tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 1, 0, 0, 0,  0, 1, 1, 32'h0,  0, 0));
`endif
    tbl.push_back(idle(1, 6, 32'h40, 1, 0));
    tbl.push_back(idle(0, 0, 32'h0,  0, 0));
    // four writers fill the window, one wb releases the fifth
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0,  0, 1, 1, 32'h0,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0,  0, 1, 1, 32'h2,  1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0,  0, 1, 1, 32'h6,  2, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0,  0, 1, 1, 32'hE,  3, 0));
    tbl.push_back(mk(1, 10, 1, 0, 0, 9, 1, 0, 1, 0, 0, 0, 1, 0, 0, 32'h1E, 4, 0));
    tbl.push_back(mk(1, 10, 1, 0, 0, 9, 1, 0, 1, 0, 1, 1, 1, 0, 0, 32'h1E, 4, 0));
    tbl.push_back(mk(1, 10, 1, 0, 0, 9, 1, 0, 1, 0, 0, 0, 0, 1, 1, 32'h1C, 3, 0));
    tbl.push_back(idle(1, 2, 32'h21C, 4, 0));
    tbl.push_back(idle(1, 3, 32'h218, 3, 0));
    // CSR drains two outstanding writers
    tbl.push_back(mk(1, 0, 0, 0, 0, 12, 1, 1, 1, 0, 0, 0, 1, 0, 0, 32'h210, 2, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 12, 1, 1, 1, 0, 0, 0, 1, 0, 0, 32'h210, 2, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 12, 1, 1, 1, 0, 1, 4, 1, 0, 0, 32'h210, 2, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 12, 1, 1, 1, 0, 1, 9, 1, 0, 0, 32'h200, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 12, 1, 1, 1, 0, 0, 0, 0, 1, 1, 32'h0,   0, 0));
    tbl.push_back(idle(1, 12, 32'h1000, 1, 0));
    tbl.push_back(idle(0, 0,  32'h0,    0, 0));
    // same-index set/clear collision, then stray wbs
    tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 1, 7,  0, 1, 1, 32'h0,  0, 0));
    tbl.push_back(idle(0, 0,  32'h80, 0, 0));
    tbl.push_back(idle(1, 7,  32'h80, 0, 0));
    tbl.push_back(idle(1, 20, 32'h0,  0, 0));
    tbl.push_back(idle(0, 0,  32'h0,  0, 0));
    // x0 writer, flush of a stalled instruction, ex_ready low
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0,  0, 1, 1, 32'h0,   0, 0));
    tbl.push_back(idle(0, 0, 32'h0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0, 0,  0, 1, 1, 32'h0,   0, 0));
    tbl.push_back(mk(1, 0, 0, 8, 1, 13, 1, 0, 1, 0, 0, 0, 1, 0, 0, 32'h100, 1, 0));
    tbl.push_back(mk(1, 0, 0, 8, 1, 13, 1, 0, 1, 1, 0, 0, 1, 0, 1, 32'h100, 1, 0));
    tbl.push_back(idle(0, 0, 32'h100, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h100, 1, 0));
    tbl.push_back(idle(0, 0, 32'h100, 1, 0));
    // build up three writers, CSR into DRAIN, flush out of DRAIN, DRAIN again
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0,  0, 1, 1, 32'h100, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0,  0, 1, 1, 32'h102, 2, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  1, 0, 0, 32'h106, 3, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0,  1, 0, 1, 32'h106, 3, 1));
    tbl.push_back(idle(0, 0, 32'h106, 3, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  1, 0, 0, 32'h106, 3, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  1, 0, 0, 32'h106, 3, 1));

    // Reset with a live instruction presented: outputs must stay quiet.
    drive(mk(1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    repeat (3) @(negedge clk);
    #1;
    check_all(-1, 1'b0, 1'b0, 1'b1, 32'h0, 3'd0, 1'b0);
    drive(idle(0, 0, 32'h0, 0, 0));
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check_all(i, tbl[i].e_stall, tbl[i].e_iss, tbl[i].e_rdy,
                tbl[i].e_busy, tbl[i].e_cnt, tbl[i].e_st);
    end

    // Asynchronous reset while in DRAIN with three writers outstanding.
    #2;
    rst_n = 1'b0;
    #1;
    check_all(100, 1'b0, 1'b0, 1'b1, 32'h0, 3'd0, 1'b0);
    @(negedge clk);
    drive(idle(0, 0, 32'h0, 0, 0));
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_all(101, 1'b0, 1'b0, 1'b1, 32'h0, 3'd0, 1'b0);
    drive(mk(1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0, 0, 1, 1, 32'h0, 0, 0));
    #1;
    check_all(102, 1'b0, 1'b1, 1'b1, 32'h0, 3'd0, 1'b0);
    @(negedge clk);
    drive(idle(0, 0, 32'h0, 0, 0));
    #1;
    check_all(103, 1'b0, 1'b0, 1'b1, 32'h8, 3'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
